// File: rtl/nn_rv_pkg.sv
// nn_rv_pkg: shared encodings for the nnRv multi-cycle core.
// Opcodes, instruction fields, MMIO map and the FSM state type.
package nn_rv_pkg;

  localparam int MOP_LSB = 29;
  localparam int SOP_LSB = 24;
  localparam int RD_LSB  = 19;
  localparam int RS1_LSB = 14;
  localparam int RS2_LSB = 9;

  localparam logic [2:0] MOP_UIMM = 3'd0;
  localparam logic [2:0] MOP_LOGI = 3'd1;
  localparam logic [2:0] MOP_MEMY = 3'd2;
  localparam logic [2:0] MOP_JUMP = 3'd3;
  localparam logic [2:0] MOP_SYS  = 3'd7;

  localparam logic [4:0] SOP_UL   = 5'd0;
  localparam logic [4:0] SOP_UH   = 5'd1;
  localparam logic [4:0] SOP_ADD  = 5'd0;
  localparam logic [4:0] SOP_SUB  = 5'd1;
  localparam logic [4:0] SOP_LLS  = 5'd2;
  localparam logic [4:0] SOP_LRS  = 5'd3;
  localparam logic [4:0] SOP_ARS  = 5'd4;
  localparam logic [4:0] SOP_AND  = 5'd5;
  localparam logic [4:0] SOP_OR   = 5'd6;
  localparam logic [4:0] SOP_XOR  = 5'd7;
  localparam logic [4:0] SOP_LD   = 5'd0;
  localparam logic [4:0] SOP_ST   = 5'd1;
  localparam logic [4:0] SOP_EQ   = 5'd0;
  localparam logic [4:0] SOP_NE   = 5'd1;
  localparam logic [4:0] SOP_LTU  = 5'd2;
  localparam logic [4:0] SOP_GEU  = 5'd3;
  localparam logic [4:0] SOP_HALT = 5'd0;

  localparam logic [31:0] KEY_ADDR   = 32'h8000_0000;
  localparam logic [31:0] OUT_ADDR   = 32'h8000_0004;
  localparam logic [31:0] CYCLE_ADDR = 32'h8000_0F00;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    LOAD,
    HALT
  } state_t;

  typedef struct packed {
    logic [2:0]  mop;
    logic [4:0]  sop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] uimm;
  } ins_t;

  function automatic ins_t decode(input logic [31:0] w);
    ins_t i;
    i.mop  = w[MOP_LSB +: 3];
    i.sop  = w[SOP_LSB +: 5];
    i.rd   = w[RD_LSB +: 5];
    i.rs1  = w[RS1_LSB +: 5];
    i.rs2  = w[RS2_LSB +: 5];
    i.uimm = w[15:0];
    return i;
  endfunction

endpackage

// File: rtl/nn_rv_alu.sv
// nn_rv_alu: combinational LOGI datapath and branch comparator.
// The same sop field selects the operation and the branch condition.
module nn_rv_alu
  import nn_rv_pkg::*;
(
  input  logic [4:0]  sop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        taken
);

  // arithmetic, shift and bitwise result
  always_comb begin
    res = '0;
    unique case (sop)
      SOP_ADD: res = a + b;
      SOP_SUB: res = a - b;
      SOP_LLS: res = a << b[4:0];
      SOP_LRS: res = a >> b[4:0];
      SOP_ARS: res = $unsigned($signed(a) >>> b[4:0]);
      SOP_AND: res = a & b;
      SOP_OR:  res = a | b;
      SOP_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end

  // branch condition; undefined conditions never take
  always_comb begin
    taken = 1'b0;
    unique case (sop)
      SOP_EQ:  taken = (a == b);
      SOP_NE:  taken = (a != b);
      SOP_LTU: taken = (a < b);
      SOP_GEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/nn_rv_mc_core.sv
// nn_rv_mc_core: multi-cycle nnRv core with inferred sync-read RAM.
// FETCH/EXEC/LOAD/HALT sequencing, MMIO outputs, key and cycle counter.
module nn_rv_mc_core
  import nn_rv_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int NUM_OUT   = 4,
  parameter int KEY_W     = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [KEY_W-1:0]             KEY,
  input  logic                         LD_EN,
  input  logic [$clog2(RAM_WORDS)-1:0] LD_ADDR,
  input  logic [31:0]                  LD_DATA,
  output logic [32*NUM_OUT-1:0]        OUT_DATA,
  output logic [NUM_OUT-1:0]           OUT_WE,
  output logic                         HALTED,
  output logic [31:0]                  DBG_PC
);

  localparam int AW = $clog2(RAM_WORDS);

  state_t              state;
  logic [31:0]         regs [32];
  logic [31:0]         mem [RAM_WORDS];
  logic [31:0]         ram_q;
  logic [31:0]         cycle;
  logic [4:0]          ld_rd;
  logic [32*NUM_OUT-1:0] out_q;
  logic [NUM_OUT-1:0]  we_q;

  ins_t        d;
  logic [31:0] pc;
  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic [31:0] rdv;
  logic [31:0] maddr;
  logic [31:0] alu_res;
  logic        alu_taken;

  logic               key_hit;
  logic               cyc_hit;
  logic [NUM_OUT-1:0] out_sel;
  logic [31:0]        out_rd;

  logic               wr_en;
  logic [31:0]        wr_val;
  logic [31:0]        pc_nxt;
  state_t             go;
  logic               st_ram;
  logic [NUM_OUT-1:0] st_out;

  logic [AW-1:0]      ram_addr;
  logic               ram_wen;
  logic [31:0]        ram_wd;

  assign d     = decode(ram_q);
  assign pc    = regs[31];
  assign rs1v  = regs[d.rs1];
  assign rs2v  = regs[d.rs2];
  assign rdv   = regs[d.rd];
  assign maddr = rs1v + rs2v;

  nn_rv_alu u_alu (
    .sop   (d.sop),
    .a     (rs1v),
    .b     (rs2v),
    .res   (alu_res),
    .taken (alu_taken)
  );

  // exact-address MMIO decode and channel readback
  always_comb begin
    key_hit = (maddr == KEY_ADDR);
    cyc_hit = (maddr == CYCLE_ADDR);
    out_sel = '0;
    out_rd  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_sel[k] = (maddr == OUT_ADDR + 32'(4 * k));
      if (out_sel[k]) out_rd = out_rd | out_q[32*k +: 32];
    end
  end

  // execute-stage decode: register write, next PC, next state
  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    pc_nxt = pc + 32'd4;
    go     = FETCH;
    st_ram = 1'b0;
    st_out = '0;
    unique case (d.mop)
      MOP_UIMM: begin
        if (d.sop == SOP_UL) begin
          wr_en  = 1'b1;
          wr_val = {rdv[31:16], d.uimm};
        end else if (d.sop == SOP_UH) begin
          wr_en  = 1'b1;
          wr_val = {d.uimm, rdv[15:0]};
        end
      end
      MOP_LOGI: begin
        if (d.sop < 5'd8) begin
          wr_en  = 1'b1;
          wr_val = alu_res;
        end
      end
      MOP_MEMY: begin
        if (d.sop == SOP_LD) begin
          if (key_hit) begin
            wr_en  = 1'b1;
            wr_val = 32'(KEY);
          end else if (|out_sel) begin
            wr_en  = 1'b1;
            wr_val = out_rd;
          end else if (cyc_hit) begin
            wr_en  = 1'b1;
            wr_val = cycle;
          end else begin
            go     = LOAD;
            pc_nxt = pc;
          end
        end else if (d.sop == SOP_ST) begin
          if (|out_sel) st_out = out_sel;
          else if (!(key_hit || cyc_hit)) st_ram = 1'b1;
        end
      end
      MOP_JUMP: begin
        if (alu_taken) pc_nxt = rdv;
      end
      MOP_SYS: begin
        if (d.sop == SOP_HALT) begin
          go     = HALT;
          pc_nxt = pc;
        end
      end
      default: ;
    endcase
  end

  // single RAM port: loader in reset, data address in EXEC, else PC
  always_comb begin
    if (!RST_N) begin
      ram_addr = LD_ADDR;
      ram_wen  = LD_EN;
      ram_wd   = LD_DATA;
    end else begin
      ram_addr = (state == EXEC) ? maddr[AW+1:2] : pc[AW+1:2];
      ram_wen  = (state == EXEC) && st_ram;
      ram_wd   = rdv;
    end
  end

  // synchronous-read RAM, contents survive reset
  always_ff @(posedge CLK) begin
    if (ram_wen) mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end

  // free-running cycle counter, keeps counting while halted
  always_ff @(posedge CLK) begin
    if (!RST_N) cycle <= '0;
    else        cycle <= cycle + 32'd1;
  end

  // core sequencer with register file and output channels
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= FETCH;
      ld_rd <= '0;
      out_q <= '0;
      we_q  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      we_q <= '0;
      unique case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          ld_rd     <= d.rd;
          regs[31]  <= pc_nxt;
          if (wr_en) regs[d.rd] <= wr_val;
          for (int k = 0; k < NUM_OUT; k++) begin
            if (st_out[k]) begin
              out_q[32*k +: 32] <= rdv;
              we_q[k]           <= 1'b1;
            end
          end
          state <= go;
        end
        LOAD: begin
          regs[31]    <= pc + 32'd4;
          regs[ld_rd] <= ram_q;
          state       <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign OUT_DATA = out_q;
  assign OUT_WE   = we_q;
  assign HALTED   = (state == HALT);
  assign DBG_PC   = regs[31];

endmodule

// File: tb/tb_nn_rv_mc_core.sv
// tb_nn_rv_mc_core: directed and random programs against an ISA-level
// model that tracks registers, RAM, outputs and per-edge PC.
module tb_nn_rv_mc_core;

  localparam int RW = 1024;
  localparam int NO = 4;
  localparam logic [31:0] OB = 32'h8000_0004;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [3:0]   KEY = '0;
  logic         LD_EN = 1'b0;
  logic [9:0]   LD_ADDR = '0;
  logic [31:0]  LD_DATA = '0;
  logic [127:0] OUT_DATA;
  logic [3:0]   OUT_WE;
  logic         HALTED;
  logic [31:0]  DBG_PC;

  nn_rv_mc_core #(.RAM_WORDS(RW), .NUM_OUT(NO), .KEY_W(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .KEY      (KEY),
    .LD_EN    (LD_EN),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .OUT_DATA (OUT_DATA),
    .OUT_WE   (OUT_WE),
    .HALTED   (HALTED),
    .DBG_PC   (DBG_PC)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mm [RW];
  int          plen;
  logic [31:0] m_out [NO];
  int          m_we [NO];
  int          m_halt;
  logic [31:0] m_trace [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(int mop, int sop, int rd, int a, int b);
    return {mop[2:0], sop[4:0], rd[4:0], a[4:0], b[4:0], 9'd0};
  endfunction

  function automatic logic [31:0] ui(int sop, int rd, int imm);
    return {3'd0, sop[4:0], rd[4:0], 3'd0, imm[15:0]};
  endfunction

  task automatic emit(input logic [31:0] w);
    mm[plen] = w;
    plen++;
  endtask

  task automatic ul(int rd, int imm); emit(ui(0, rd, imm)); endtask
  task automatic uh(int rd, int imm); emit(ui(1, rd, imm)); endtask
  task automatic logi(int s, int rd, int a, int b); emit(ins(1, s, rd, a, b)); endtask
  task automatic ld(int rd, int a, int b); emit(ins(2, 0, rd, a, b)); endtask
  task automatic st(int rd, int a, int b); emit(ins(2, 1, rd, a, b)); endtask
  task automatic jmp(int s, int rd, int a, int b); emit(ins(3, s, rd, a, b)); endtask
  task automatic halt(); emit(ins(7, 0, 0, 0, 0)); endtask

  function automatic int rr();
    return $urandom_range(1, 15);
  endfunction

  function automatic int moff();
    int offs [7] = '{0, 4, 8, 12, 16, 20, 'hF00};
    return offs[$urandom_range(0, 6)];
  endfunction

  // instruction-level interpreter; latency 2, RAM load 3, halt at +2
  task automatic run_model();
    logic [31:0] R [32];
    logic [31:0] pc, w, a, b, dv, wv, npc, addr;
    int t, lat, mop, sop, rd, ch;
    bit wr;
    for (int i = 0; i < 32; i++) R[i] = '0;
    for (int k = 0; k < NO; k++) begin m_out[k] = '0; m_we[k] = 0; end
    m_trace.delete();
    m_halt = -1;
    t = 0;
    pc = '0;
    for (int s = 0; s < 5000 && m_halt < 0; s++) begin
      w   = mm[(pc >> 2) % RW];
      mop = int'(w[31:29]);
      sop = int'(w[28:24]);
      rd  = int'(w[23:19]);
      a   = R[w[18:14]];
      b   = R[w[13:9]];
      dv  = R[rd];
      wr  = 0;
      wv  = '0;
      lat = 2;
      npc = pc + 4;
      case (mop)
        0: begin
          if (sop == 0) begin wr = 1; wv = {dv[31:16], w[15:0]}; end
          else if (sop == 1) begin wr = 1; wv = {w[15:0], dv[15:0]}; end
        end
        1: if (sop < 8) begin
          wr = 1;
          case (sop)
            0: wv = a + b;
            1: wv = a - b;
            2: wv = a << b[4:0];
            3: wv = a >> b[4:0];
            4: wv = $unsigned($signed(a) >>> b[4:0]);
            5: wv = a & b;
            6: wv = a | b;
            default: wv = a ^ b;
          endcase
        end
        2: begin
          addr = a + b;
          ch = -1;
          if (addr >= OB && addr < OB + 4 * NO && addr % 4 == 0)
            ch = int'((addr - OB) / 4);
          if (sop == 0) begin
            wr = 1;
            if (addr == 32'h8000_0000) wv = {28'd0, KEY};
            else if (ch >= 0) wv = m_out[ch];
            else if (addr == 32'h8000_0F00) wv = t + 1;
            else begin wv = mm[(addr >> 2) % RW]; lat = 3; end
          end else if (sop == 1) begin
            if (ch >= 0) begin m_out[ch] = dv; m_we[ch]++; end
            else if (addr != 32'h8000_0000 && addr != 32'h8000_0F00)
              mm[(addr >> 2) % RW] = dv;
          end
        end
        3: if ((sop == 0 && a == b) || (sop == 1 && a != b) ||
               (sop == 2 && a < b) || (sop == 3 && a >= b)) npc = dv;
        7: if (sop == 0) m_halt = t + 2;
        default: ;
      endcase
      if (m_halt < 0) begin
        repeat (lat - 1) m_trace.push_back(pc);
        R[31] = npc;
        if (wr) R[rd] = wv;
        m_trace.push_back(R[31]);
        pc = R[31];
        t += lat;
      end
    end
  endtask

  // hold reset, push mm[0..n-1] through the load port, check reset state
  task automatic load_prog(input string name, input int n);
    RST_N = 1'b0;
    for (int i = 0; i < n; i++) begin
      LD_EN = 1'b1;
      LD_ADDR = 10'(i);
      LD_DATA = mm[i];
      @(posedge CLK); #1;
    end
    LD_EN = 1'b0;
    @(posedge CLK); #1;
    for (int k = 0; k < NO; k++)
      chk($sformatf("%s rst out%0d", name, k), OUT_DATA[32*k +: 32], 0);
    chk({name, " rst we"}, 32'(OUT_WE), 0);
    chk({name, " rst halted"}, 32'(HALTED), 0);
    chk({name, " rst pc"}, DBG_PC, 0);
  endtask

  // load current program, run to halt, compare PC trace and outputs
  task automatic run_dut(input string name);
    int we_cnt [NO];
    int lim;
    bit tr_ok;
    load_prog(name, plen);
    run_model();
    for (int k = 0; k < NO; k++) we_cnt[k] = 0;
    lim = (m_halt > 0) ? m_halt + 2 : 4000;
    tr_ok = 1;
    LD_EN = 1'b1;
    LD_ADDR = 10'($urandom_range(0, plen - 1));
    LD_DATA = ins(7, 0, 0, 0, 0);
    RST_N = 1'b1;
    for (int n = 1; n <= lim; n++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < NO; k++) if (OUT_WE[k]) we_cnt[k]++;
      if (tr_ok && n <= m_trace.size()) begin
        chk($sformatf("%s pc@%0d", name, n), DBG_PC, m_trace[n-1]);
        tr_ok = (DBG_PC === m_trace[n-1]);
      end
      if (n == m_halt - 1) chk({name, " halted early"}, 32'(HALTED), 0);
      if (n == m_halt) chk({name, " halted"}, 32'(HALTED), 1);
    end
    LD_EN = 1'b0;
    chk({name, " halted end"}, 32'(HALTED), 1);
    for (int k = 0; k < NO; k++) begin
      chk($sformatf("%s out%0d", name, k), OUT_DATA[32*k +: 32], m_out[k]);
      chk($sformatf("%s we%0d", name, k), we_cnt[k], m_we[k]);
    end
  endtask

  task automatic gen_random(input int nops);
    int sk;
    plen = 0;
    ul(20, 'h800);
    uh(22, 'h8000);
    for (int r = 1; r < 16; r++) begin
      ul(r, $urandom);
      uh(r, $urandom);
    end
    for (int i = 0; i < nops; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: logi(($urandom_range(0, 9) == 0) ? $urandom_range(8, 31)
                      : $urandom_range(0, 7), rr(), rr(), rr());
        3: emit(ui($urandom_range(0, 1), rr(), $urandom));
        4: begin ul(21, 4 * $urandom_range(0, 511)); st(rr(), 20, 21); end
        5: begin ul(21, 4 * $urandom_range(0, 511)); ld(rr(), 20, 21); end
        6: begin ul(23, moff()); st(rr(), 22, 23); end
        7: begin ul(23, moff()); ld(rr(), 22, 23); end
        8: begin
          sk = $urandom_range(0, 3);
          ul(24, 4 * (plen + 2 + sk));
          jmp($urandom_range(0, 3), 24, rr(), rr());
          repeat (sk) logi($urandom_range(0, 7), rr(), rr(), rr());
        end
        default: begin
          case ($urandom_range(0, 4))
            0: emit(ins($urandom_range(4, 6), $urandom_range(0, 31), rr(), rr(), rr()));
            1: emit(ins(7, $urandom_range(1, 31), rr(), rr(), rr()));
            2: emit(ins(3, $urandom_range(4, 31), rr(), rr(), rr()));
            3: emit(ins(2, $urandom_range(2, 31), rr(), 20, 21));
            default: emit(ui($urandom_range(2, 31), rr(), $urandom));
          endcase
        end
      endcase
    end
    for (int k = 0; k < NO; k++) begin
      ul(23, 4 * (k + 1));
      st(k + 1, 22, 23);
    end
    halt();
  endtask

  initial begin
    for (int i = 0; i < RW; i++) mm[i] = $urandom;
    load_prog("fill", RW);

    plen = 0;
    ul(1, 5); ul(2, 7); logi(0, 3, 1, 2);
    uh(4, 'h8000); ul(4, 4); st(3, 4, 0); halt();
    run_dut("t1");
    chk("t1 sum", OUT_DATA[31:0], 12);

    plen = 0;
    uh(1, 'hDEAD); ul(1, 'hBEEF); ul(2, 400);
    st(1, 2, 0); ld(5, 2, 0);
    uh(4, 'h8000); ul(4, 8); st(5, 4, 0); halt();
    run_dut("t2");
    chk("t2 ch1", OUT_DATA[63:32], 32'hDEAD_BEEF);

    plen = 0;
    ul(1, 3); ul(2, 1); ul(6, 12);
    logi(1, 1, 1, 2); logi(0, 8, 8, 2); jmp(1, 6, 1, 0);
    uh(9, 'h8000); ul(9, 4); st(8, 9, 0); halt();
    run_dut("t3");
    chk("t3 loops", OUT_DATA[31:0], 3);

    KEY = 4'b1010;
    plen = 0;
    uh(4, 'h8000); uh(9, 'h8000); ul(9, 4);
    ld(5, 4, 0); st(5, 9, 0);
    ul(2, 'h1234); st(2, 4, 0); ld(6, 4, 0);
    ul(9, 8); st(6, 9, 0); halt();
    run_dut("t4");
    chk("t4 key", OUT_DATA[31:0], 32'h0000_000A);
    chk("t4 key after st", OUT_DATA[63:32], 32'h0000_000A);

    plen = 0;
    ul(7, 'h40); uh(10, 'h8000); ul(10, 'hF00);
    emit(ins(5, 3, 1, 1, 1));
    ld(11, 10, 0);
    uh(9, 'h8000); ul(9, 16); st(11, 9, 0);
    logi(0, 31, 0, 7);
    while (plen < 16) halt();
    ul(12, 'h77); ul(9, 12); st(12, 9, 0); halt();
    run_dut("t5");
    chk("t5 cycle", OUT_DATA[127:96], 9);
    chk("t5 jump", OUT_DATA[95:64], 32'h77);

    plen = 0;
    ul(1, 'h55); uh(2, 'h8000); ul(2, 4); st(1, 2, 0);
    ul(3, 'h800); ld(5, 3, 0); st(5, 2, 0); halt();
    load_prog("t6", plen);
    RST_N = 1'b1;
    repeat (12) begin @(posedge CLK); #1; end
    chk("t6 pc in load", DBG_PC, 20);
    chk("t6 out before", OUT_DATA[31:0], 32'h55);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("t6 abort we", 32'(OUT_WE), 0);
    for (int k = 0; k < NO; k++)
      chk($sformatf("t6 abort out%0d", k), OUT_DATA[32*k +: 32], 0);
    chk("t6 abort pc", DBG_PC, 0);
    chk("t6 abort halted", 32'(HALTED), 0);
    run_dut("t6b");

    for (int r = 0; r < 6; r++) begin
      KEY = 4'($urandom);
      gen_random(40);
      run_dut($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
